sseg_scan_driver: RTL
=====================

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits (legal range 1..8).
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot (legal minimum 4).
REQ-003 Parameter GUARD_CYC, default 2: all-anodes-off cycles at the start of each slot (legal range 0..REFRESH_DIV-2).
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 value  in  4*N_DIGITS  hex nibbles; nibble k drives digit k, with digit 0 as least significant.
REQ-007 load  in  1  single-cycle strobe that captures value, dp_mask and blank_mask.
REQ-008 dp_mask  in  N_DIGITS  bit k=1 lights the decimal point of digit k.
REQ-009 blank_mask  in  N_DIGITS  bit k=1 forces digit k dark.
REQ-010 lzs  in  1  leading-zero suppression enable; live input, not latched.
REQ-011 sseg  out  7  segments {a,b,c,d,e,f,g}, active-low.
REQ-012 dp  out  1  decimal point, active-low.
REQ-013 an  out  N_DIGITS  digit anodes, active-low, at most one bit low at any time.
REQ-014 frame  out  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Slot counter cnt counts 0..REFRESH_DIV-1; on REFRESH_DIV-1 it wraps to 0 and asserts internal tick for that cycle.
REQ-016 Digit index idx advances on each tick: 0,1,...,N_DIGITS-1, then wraps to 0.
REQ-017 Frame boundary = tick while idx==N_DIGITS-1; frame is registered and pulses in the cycle after the boundary.
REQ-018 load captures value/dp_mask/blank_mask into a pending shadow and sets pend_valid.
REQ-019 At a frame boundary with pend_valid=1, the shadow copies into the display register and pend_valid clears; display content changes only between frames (no tearing).
REQ-020 load coincident with a frame boundary: the new inputs go directly to the display register; pend_valid ends 0.
REQ-021 Repeated loads within one frame: the last load wins; earlier loads are discarded.
REQ-022 Nibble decode, as {a..g} with 0 = lit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-023 Digit k is dark (sseg=1111111, dp=1, an[k]=1) if blank_mask[k]=1, or if lzs=1, k>0 and all display nibbles k..N_DIGITS-1 are zero.
REQ-024 Digit 0 is never suppressed by lzs; value 0 with lzs=1 shows a single "0".
REQ-025 During cnt<GUARD_CYC, an is all ones; sseg/dp may already carry the new digit.
REQ-026 sseg, dp, an and frame are registered: each output reflects idx/cnt/display-register state one clock later.
REQ-027 No counter width may overflow for any legal parameter value; widths are $clog2-derived.

Reset
REQ-028 While rst=1 at a rising edge: cnt=0, idx=0, pend_valid=0, shadow and display registers all zero, sseg=1111111, dp=1, an all ones, frame=0.
REQ-029 Reset mid-frame or mid-slot abandons the scan immediately; a load in the same cycle as rst is ignored.
REQ-030 The first slot after reset release is digit 0 and includes the full guard interval.

Structure
REQ-031 The 16-entry segment table and the constants SEG_OFF=7'b1111111 and the active-low polarity go in shared package sseg_pkg.
REQ-032 Sub-module hex_sseg_lut (combinational, 4-bit nibble in, 7-bit out) implements REQ-022 and is instantiated once, after the digit mux.

Verification (N_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1)
REQ-033 Reset, then load value=16'h12AF, masks 0, lzs=0 -> after the next frame pulse, slots show an=1110/1101/1011/0111 with sseg=0111000/0001000/0010010/1001111, and an=1111 on the first cycle of each slot.
REQ-034 value=16'h0040, lzs=1 -> digits 3 and 2 dark, digit 1 shows 1001100, digit 0 shows 0000001; value=0 -> only digit 0 is lit.
REQ-035 load 16'h1111 then load 16'h2222 in the same frame -> the next frame shows only "2"; load asserted on the exact boundary cycle -> that frame shows the new value.
REQ-036 dp_mask=4'b0100, blank_mask=4'b1000 -> dp=0 only in the digit-2 slot; digit 3 is dark and its an bit stays 1.
REQ-037 rst asserted at cnt=2, idx=2 -> next cycle all outputs are at reset values; after release, the scan restarts at digit 0 and the display register is zero.
REQ-038 Assertion over the whole run: $countones(~an)<=1 every cycle, and frame pulses every 16 cycles.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//
// Contents:
//   nibble_t / seg_t  - one hex nibble, one 7-bit segment word {a,b,c,d,e,f,g}
//   SEG_ON            - level that lights a segment or decimal point (active-low)
//   SEG_OFF           - segment word with every segment dark
//   SEG_TABLE         - glyphs for the hex digits 0..F
//   hex_to_seg()      - table lookup helper used by hex_sseg_lut
package sseg_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam logic SEG_ON  = 1'b0;
    localparam seg_t SEG_OFF = 7'b1111111;

    // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001,   // 0
        7'b1001111,   // 1
        7'b0010010,   // 2
        7'b0000110,   // 3
        7'b1001100,   // 4
        7'b0100100,   // 5
        7'b0100000,   // 6
        7'b0001111,   // 7
        7'b0000000,   // 8
        7'b0000100,   // 9
        7'b0001000,   // A
        7'b1100000,   // b
        7'b0110001,   // C
        7'b1000010,   // d
        7'b0110000,   // E
        7'b0111000    // F
    };

    function automatic seg_t hex_to_seg(input nibble_t nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/hex_sseg_lut.sv
// Combinational hex-to-seven-segment decoder.
//
// Ports:
//   nibble  in  4  hex digit to display
//   seg     out 7  segments {a,b,c,d,e,f,g}, active-low
module hex_sseg_lut
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed driver for an N_DIGITS common-anode seven-segment display.
//
// Each digit owns a slot of REFRESH_DIV clocks; the first GUARD_CYC clocks of a
// slot keep every anode off so the segment lines can settle without ghosting.
// New content is staged in a shadow register by 'load' and only moves into the
// display register at a frame boundary, so a frame never mixes old and new data.
//
// Parameters:
//   N_DIGITS     number of digits (1..8)
//   REFRESH_DIV  clocks per digit slot (>= 4)
//   GUARD_CYC    anode-off clocks at the start of each slot (0..REFRESH_DIV-2)
//
// Ports:
//   clk         in   1           system clock, rising edge
//   rst         in   1           synchronous active-high reset
//   value       in   4*N_DIGITS  hex nibbles, nibble k drives digit k
//   load        in   1           strobe capturing value/dp_mask/blank_mask
//   dp_mask     in   N_DIGITS    1 lights the decimal point of digit k
//   blank_mask  in   N_DIGITS    1 forces digit k dark
//   lzs         in   1           leading-zero suppression (live input)
//   sseg        out  7           segments {a..g}, active-low, registered
//   dp          out  1           decimal point, active-low, registered
//   an          out  N_DIGITS    digit anodes, active-low, registered
//   frame       out  1           one-cycle pulse after each frame boundary
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic                    lzs,
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   tick;
    logic                   boundary;

    logic [4*N_DIGITS-1:0]  shadow_value;
    logic [N_DIGITS-1:0]    shadow_dp;
    logic [N_DIGITS-1:0]    shadow_blank;
    logic                   pend_valid;

    logic [4*N_DIGITS-1:0]  disp_value;
    logic [N_DIGITS-1:0]    disp_dp;
    logic [N_DIGITS-1:0]    disp_blank;

    logic [N_DIGITS-1:0]    lead_zero;
    nibble_t                cur_nib;
    logic                   cur_dark;
    logic                   in_guard;
    seg_t                   lut_seg;

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    // Slot counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow/display double buffer. A load that lands on the boundary itself
    // bypasses the shadow so it is not held back a whole extra frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            pend_valid   <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_blank   <= '0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (load) begin
                disp_value <= value;
                disp_dp    <= dp_mask;
                disp_blank <= blank_mask;
            end else if (pend_valid) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                disp_blank <= shadow_blank;
            end
        end else if (load) begin
            shadow_value <= value;
            shadow_dp    <= dp_mask;
            shadow_blank <= blank_mask;
            pend_valid   <= 1'b1;
        end
    end

    // lead_zero[k] is set when nibbles k..N_DIGITS-1 of the display are all zero.
    always_comb begin
        logic acc;
        lead_zero = '0;
        acc       = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            acc          = acc & (disp_value[4*k +: 4] == 4'h0);
            lead_zero[k] = acc;
        end
    end

    assign cur_nib  = disp_value[{idx, 2'b00} +: 4];
    assign cur_dark = disp_blank[idx] | (lzs & (idx != '0) & lead_zero[idx]);
    assign in_guard = (int'(cnt) < GUARD_CYC);

    hex_sseg_lut u_lut (
        .nibble (cur_nib),
        .seg    (lut_seg)
    );

    // Registered pin drivers; the anode goes off for dark digits and guard time.
    always_ff @(posedge clk) begin
        if (rst) begin
            sseg  <= SEG_OFF;
            dp    <= ~SEG_ON;
            an    <= '1;
            frame <= 1'b0;
        end else begin
            sseg  <= cur_dark ? SEG_OFF : lut_seg;
            dp    <= (cur_dark || !disp_dp[idx]) ? ~SEG_ON : SEG_ON;
            an    <= (cur_dark || in_guard) ? '1 : ~(N_DIGITS'(1) << idx);
            frame <= boundary;
        end
    end

endmodule
